oflow_feature_mem_ctrl: RTL and testbench
=========================================

OFLOW_FEATURE_MEM_CTRL -- requirements
Module: oflow_feature_mem_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH_MEM, default 290, feature-vector width; ADDR_WIDTH, default 8, memory address width; RAM_DEPTH, default 1<<ADDR_WIDTH, number of rows.
REQ-002 One clock, clk; reset is asynchronous and active-high, port reset; all state SHALL use posedge clk / posedge reset.
REQ-003 Ports SHALL be, in this order:
- clk  in  1  clock
- reset  in  1  async active-high reset
- clear  in  1  frame restart: empties the store
- wr_valid  in  1  feature offered
- wr_data  in  DATA_WIDTH_MEM  feature vector
- wr_ready  out  1  feature accepted when wr_valid&&wr_ready
- wr_flush  in  1  force out a half-filled pair
- rd_req  in  1  read request
- rd_addr  in  ADDR_WIDTH  row to read
- rd_ready  out  1  request accepted when rd_req&&rd_ready
- rd_valid  out  1  read response strobe, 1 cycle
- rd_data  out  DATA_WIDTH_MEM  read response
- rd_err  out  1  with rd_valid: address out of range
- count  out  ADDR_WIDTH+1  rows committed to memory
- address_0, address_1  out  ADDR_WIDTH  memory port addresses
- data_in_0, data_in_1  out  DATA_WIDTH_MEM  memory write data
- csb_0, csb_1, web_0, web_1, oeb_0, oeb_1  out  1 each  active-low memory controls
- data_out_0  in  DATA_WIDTH_MEM  memory port-0 read data

Function
REQ-004 Memory control outputs SHALL be registered; memory returns data_out_0 one cycle after a port-0 read cycle (csb_0=0, web_0=1, oeb_0=0).
REQ-005 Write FSM SHALL have states EMPTY (no buffered feature) and HOLD (one feature in hold register).
REQ-006 EMPTY + accepted feature -> HOLD, feature captured in hold register.
REQ-007 HOLD + accepted feature -> EMPTY; next cycle port 0 writes hold register to wr_ptr and port 1 writes new feature to wr_ptr+1 (csb=0, web=0 on both); wr_ptr += 2, count += 2.
REQ-008 HOLD + wr_flush with no accepted feature -> EMPTY; next cycle port 0 alone writes hold register to wr_ptr; wr_ptr += 1, count += 1; port 1 stays idle (csb_1=1).
REQ-009 wr_flush in EMPTY SHALL be ignored.
REQ-010 wr_ready SHALL be 1 only when count + (state==HOLD) < RAM_DEPTH and clear==0; no wrap-around, the store saturates at RAM_DEPTH rows.
REQ-011 wr_ptr SHALL equal count[ADDR_WIDTH-1:0]; address_1 = address_0 + 1 modulo RAM_DEPTH.
REQ-012 Read: rd_ready = !rd_busy && !write_issue_next, where write_issue_next is true when REQ-007 or REQ-008 fires this cycle; writes have priority on port 0.
REQ-013 Accepted read with rd_addr < count: next cycle port-0 read of rd_addr; the cycle after, rd_valid=1, rd_data=data_out_0, rd_err=0; total latency 2 cycles; rd_busy is set from acceptance until rd_valid.
REQ-014 Accepted read with rd_addr >= count: no memory access; rd_valid=1 two cycles later with rd_data=0 and rd_err=1.
REQ-015 Idle memory cycles: csb_0=csb_1=1, web_0=web_1=1, oeb_0=oeb_1=1, addresses and data held at last value.
REQ-016 clear SHALL set count=0 and state=EMPTY, discarding any held feature; clear wins over a simultaneous write or flush; a read in flight completes normally.

Reset
REQ-017 While reset is high: state=EMPTY, count=0, wr_ptr=0, rd_busy=0, wr_ready=0, rd_ready=0, rd_valid=0, rd_err=0, rd_data=0, all csb/web/oeb=1, addresses and data_in=0.
REQ-018 Reset mid-write or mid-read SHALL abort the operation; no memory cycle is issued after reset deasserts until a new request arrives.

Verification
REQ-019 Two features A, B accepted back-to-back from reset -> one cycle later port0 writes A @0 and port1 writes B @1; count=2.
REQ-020 Feature C, then wr_flush -> port0 writes C @2, csb_1=1; count=3; a following feature D lands @3.
REQ-021 rd_req rd_addr=1 after REQ-019 -> rd_valid two cycles later, rd_data=B, rd_err=0; rd_addr=9 -> rd_data=0, rd_err=1.
REQ-022 rd_req in the same cycle as a pair completes -> rd_ready=0 that cycle; the read is accepted the next cycle and returns correct data.
REQ-023 Fill 255 rows and hold one feature -> wr_ready=0; wr_flush -> count=256, wr_ready stays 0; clear -> count=0, wr_ready=1.
REQ-024 Assert reset while state=HOLD and a read is in flight -> all outputs at REQ-017 values; no rd_valid after release.

Source files
------------

// File: rtl/oflow_feature_mem_ctrl.sv
// Pairs incoming feature vectors into dual-port memory writes and serves single-row reads on port 0.
// Writes own port 0 in the cycle they are issued; reads are deferred by dropping rd_ready.
module oflow_feature_mem_ctrl #(
  parameter int DATA_WIDTH_MEM = 290,
  parameter int ADDR_WIDTH     = 8,
  parameter int RAM_DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      wr_valid,
  input  logic [DATA_WIDTH_MEM-1:0] wr_data,
  output logic                      wr_ready,
  input  logic                      wr_flush,
  input  logic                      rd_req,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic                      rd_ready,
  output logic                      rd_valid,
  output logic [DATA_WIDTH_MEM-1:0] rd_data,
  output logic                      rd_err,
  output logic [ADDR_WIDTH:0]       count,
  output logic [ADDR_WIDTH-1:0]     address_0,
  output logic [ADDR_WIDTH-1:0]     address_1,
  output logic [DATA_WIDTH_MEM-1:0] data_in_0,
  output logic [DATA_WIDTH_MEM-1:0] data_in_1,
  output logic                      csb_0,
  output logic                      csb_1,
  output logic                      web_0,
  output logic                      web_1,
  output logic                      oeb_0,
  output logic                      oeb_1,
  input  logic [DATA_WIDTH_MEM-1:0] data_out_0
);

  typedef enum logic {EMPTY, HOLD} state_t;

  localparam logic [ADDR_WIDTH+1:0] DEPTH = (ADDR_WIDTH+2)'(RAM_DEPTH);

  state_t                    state;
  logic [DATA_WIDTH_MEM-1:0] hold;
  logic                      rd_busy;
  logic                      rd_pend_err;
  logic [ADDR_WIDTH-1:0]     wr_ptr;
  logic [ADDR_WIDTH+1:0]     fill;
  logic                      accept;
  logic                      pair_fire;
  logic                      flush_fire;
  logic                      write_issue_next;
  logic                      rd_accept;
  logic                      rd_in_range;

  assign wr_ptr           = count[ADDR_WIDTH-1:0];
  assign fill             = {1'b0, count} + {{(ADDR_WIDTH+1){1'b0}}, state == HOLD};
  assign wr_ready         = !reset && !clear && (fill < DEPTH);
  assign accept           = wr_valid && wr_ready;
  assign pair_fire        = (state == HOLD) && accept;
  assign flush_fire       = (state == HOLD) && wr_flush && !accept && !clear;
  assign write_issue_next = pair_fire || flush_fire;
  assign rd_ready         = !reset && !rd_busy && !write_issue_next;
  assign rd_accept        = rd_req && rd_ready;
  assign rd_in_range      = {1'b0, rd_addr} < count;
  // Memory data arrives the cycle rd_valid is high, so the response is steered rather than registered.
  assign rd_data          = (rd_valid && !rd_err) ? data_out_0 : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      hold        <= '0;
      count       <= '0;
      rd_busy     <= 1'b0;
      rd_pend_err <= 1'b0;
      rd_valid    <= 1'b0;
      rd_err      <= 1'b0;
      address_0   <= '0;
      address_1   <= '0;
      data_in_0   <= '0;
      data_in_1   <= '0;
      csb_0       <= 1'b1;
      csb_1       <= 1'b1;
      web_0       <= 1'b1;
      web_1       <= 1'b1;
      oeb_0       <= 1'b1;
      oeb_1       <= 1'b1;
    end else begin
      csb_0       <= 1'b1;
      csb_1       <= 1'b1;
      web_0       <= 1'b1;
      web_1       <= 1'b1;
      oeb_0       <= 1'b1;
      oeb_1       <= 1'b1;
      rd_busy     <= rd_accept;
      rd_pend_err <= rd_accept && !rd_in_range;
      rd_valid    <= rd_busy;
      rd_err      <= rd_busy && rd_pend_err;

      if (clear) begin
        count <= '0;
        state <= EMPTY;
      end else if (pair_fire) begin
        address_0 <= wr_ptr;
        address_1 <= wr_ptr + ADDR_WIDTH'(1);
        data_in_0 <= hold;
        data_in_1 <= wr_data;
        csb_0     <= 1'b0;
        web_0     <= 1'b0;
        csb_1     <= 1'b0;
        web_1     <= 1'b0;
        count     <= count + (ADDR_WIDTH+1)'(2);
        state     <= EMPTY;
      end else if (flush_fire) begin
        address_0 <= wr_ptr;
        address_1 <= wr_ptr + ADDR_WIDTH'(1);
        data_in_0 <= hold;
        csb_0     <= 1'b0;
        web_0     <= 1'b0;
        count     <= count + (ADDR_WIDTH+1)'(1);
        state     <= EMPTY;
      end else if (accept) begin
        hold  <= wr_data;
        state <= HOLD;
      end

      if (rd_accept && rd_in_range) begin
        address_0 <= rd_addr;
        address_1 <= rd_addr + ADDR_WIDTH'(1);
        csb_0     <= 1'b0;
        oeb_0     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_oflow_feature_mem_ctrl.sv
// Bench for oflow_feature_mem_ctrl: transaction-level model of the row store and read responses,
// checked every cycle, with directed scenarios pinned by literal expectations.
module tb_oflow_feature_mem_ctrl;
  localparam int DW    = 290;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          wr_flush = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ready, rd_valid, rd_err;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic [AW-1:0] address_0, address_1;
  logic [DW-1:0] data_in_0, data_in_1;
  logic          csb_0, csb_1, web_0, web_1, oeb_0, oeb_1;
  logic [DW-1:0] data_out_0;

  oflow_feature_mem_ctrl #(.DATA_WIDTH_MEM(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .wr_flush(wr_flush),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .count(count),
    .address_0(address_0), .address_1(address_1), .data_in_0(data_in_0), .data_in_1(data_in_1),
    .csb_0(csb_0), .csb_1(csb_1), .web_0(web_0), .web_1(web_1), .oeb_0(oeb_0), .oeb_1(oeb_1),
    .data_out_0(data_out_0)
  );

  always #5 clk = ~clk;

  // Synchronous dual-port memory: port 0 read/write, port 1 write only.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (!csb_0 && !web_0) ram[address_0] <= data_in_0;
    if (!csb_0 && web_0 && !oeb_0) data_out_0 <= ram[address_0];
    if (!csb_1 && !web_1) ram[address_1] <= data_in_1;
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: committed rows, optional held feature, pending read responses,
  // and the memory activity expected in the current cycle.
  typedef struct {
    int unsigned   due;
    bit            err;
    logic [DW-1:0] data;
  } rsp_t;

  int unsigned   cyc = 0;
  int unsigned   m_count;
  bit            m_held;
  logic [DW-1:0] m_hold;
  logic [DW-1:0] m_mem [DEPTH];
  rsp_t          rsp_q[$];
  int            e0_kind, e1_kind;
  logic [AW-1:0] e0_addr, e1_addr;
  logic [DW-1:0] e0_data, e1_data;
  bit            last_wr_ready, last_rd_ready;

  task automatic model_reset();
    m_count = 0;
    m_held  = 0;
    rsp_q.delete();
    e0_kind = 0;
    e1_kind = 0;
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] d = '0;
    for (int unsigned i = 0; i < 10; i++) d = {d[DW-33:0], 32'($urandom())};
    return d;
  endfunction

  task automatic reset_vals(input string tag);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_rd_ready"}, rd_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_err"}, rd_err, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_ctl"}, {csb_0, csb_1, web_0, web_1, oeb_0, oeb_1}, 6'h3f);
    chk({tag, "_addr"}, {address_0, address_1}, 0);
    chk({tag, "_din0"}, data_in_0, 0);
    chk({tag, "_din1"}, data_in_1, 0);
  endtask

  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit fl,
                       input bit rq, input logic [AW-1:0] ra, input bit cl);
    bit   exp_wr_ready, acc, fpair, fflush, busy, exp_rd_ready, racc, vexp;
    rsp_t r;
    @(negedge clk);
    wr_valid = v; wr_data = d; wr_flush = fl; rd_req = rq; rd_addr = ra; clear = cl;
    #1;
    exp_wr_ready = !cl && (m_count + m_held < DEPTH);
    acc          = v && exp_wr_ready;
    fpair        = m_held && acc;
    fflush       = m_held && fl && !acc && !cl;
    busy         = 0;
    foreach (rsp_q[i]) if (rsp_q[i].due == cyc + 1) busy = 1;
    exp_rd_ready = !busy && !(fpair || fflush);
    racc         = rq && exp_rd_ready;
    vexp         = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);

    chk("count", count, m_count);
    chk("wr_ready", wr_ready, exp_wr_ready);
    chk("rd_ready", rd_ready, exp_rd_ready);
    last_wr_ready = wr_ready;
    last_rd_ready = rd_ready;
    chk("rd_valid", rd_valid, vexp);
    if (vexp) begin
      chk("rd_err", rd_err, rsp_q[0].err);
      chk("rd_data", rd_data, rsp_q[0].data);
    end
    case (e0_kind)
      1: begin
        chk("p0_wr_ctl", {csb_0, web_0}, 2'b00);
        chk("p0_wr_addr", address_0, e0_addr);
        chk("p0_wr_data", data_in_0, e0_data);
      end
      2: begin
        chk("p0_rd_ctl", {csb_0, web_0, oeb_0}, 3'b010);
        chk("p0_rd_addr", address_0, e0_addr);
      end
      default: chk("p0_idle", {csb_0, web_0, oeb_0}, 3'b111);
    endcase
    if (e1_kind == 1) begin
      chk("p1_wr_ctl", {csb_1, web_1}, 2'b00);
      chk("p1_wr_addr", address_1, e1_addr);
      chk("p1_wr_data", data_in_1, e1_data);
    end else begin
      chk("p1_idle", {csb_1, web_1, oeb_1}, 3'b111);
    end

    @(posedge clk);
    e0_kind = 0;
    e1_kind = 0;
    if (racc) begin
      r.due = cyc + 2;
      if (int'(ra) < m_count) begin
        r.err = 0; r.data = m_mem[ra];
        e0_kind = 2; e0_addr = ra;
      end else begin
        r.err = 1; r.data = '0;
      end
      rsp_q.push_back(r);
    end
    if (cl) begin
      m_count = 0;
      m_held  = 0;
    end else if (fpair) begin
      e0_kind = 1; e0_addr = AW'(m_count);     e0_data = m_hold;
      e1_kind = 1; e1_addr = AW'(m_count + 1); e1_data = d;
      m_mem[e0_addr] = m_hold;
      m_mem[e1_addr] = d;
      m_count += 2;
      m_held = 0;
    end else if (fflush) begin
      e0_kind = 1; e0_addr = AW'(m_count); e0_data = m_hold;
      m_mem[e0_addr] = m_hold;
      m_count += 1;
      m_held = 0;
    end else if (acc) begin
      m_held = 1;
      m_hold = d;
    end
    if (vexp) void'(rsp_q.pop_front());
    cyc++;
  endtask

  task automatic idle();
    cycle(0, '0, 0, 0, '0, 0);
  endtask

  logic [DW-1:0] fa, fb, fc, fd, fe, ff;

  initial begin
    model_reset();
    reset = 1'b1;
    wr_valid = 1'b1;
    rd_req = 1'b1;
    #12;
    reset_vals("rst");
    wr_valid = 1'b0;
    rd_req = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;

    // Pair A,B lands at rows 0 and 1.
    fa = rnd(); fb = rnd(); fc = rnd(); fd = rnd(); fe = rnd(); ff = rnd();
    cycle(1, fa, 0, 0, '0, 0);
    cycle(1, fb, 0, 0, '0, 0);
    #2;
    chk("pair_count", count, 2);
    chk("pair_addr", {address_0, address_1}, {8'd0, 8'd1});
    chk("pair_din0", data_in_0, fa);
    chk("pair_din1", data_in_1, fb);
    chk("pair_ctl", {csb_0, web_0, csb_1, web_1}, 4'b0000);

    // C then flush: port 0 alone at row 2; D follows at row 3.
    cycle(1, fc, 0, 0, '0, 0);
    cycle(0, '0, 1, 0, '0, 0);
    #2;
    chk("flush_count", count, 3);
    chk("flush_addr0", address_0, 2);
    chk("flush_din0", data_in_0, fc);
    chk("flush_csb1", csb_1, 1);
    cycle(1, fd, 0, 0, '0, 0);
    cycle(0, '0, 1, 0, '0, 0);
    #2;
    chk("d_addr0", address_0, 3);
    chk("d_din0", data_in_0, fd);

    // In-range and out-of-range reads.
    cycle(0, '0, 0, 1, 8'd1, 0);
    idle();
    #2;
    chk("rd1_valid", rd_valid, 1);
    chk("rd1_data", rd_data, fb);
    chk("rd1_err", rd_err, 0);
    idle();
    cycle(0, '0, 0, 1, 8'd9, 0);
    idle();
    #2;
    chk("rd9_valid", rd_valid, 1);
    chk("rd9_data", rd_data, 0);
    chk("rd9_err", rd_err, 1);
    idle();

    // Read colliding with a completing pair is held off one cycle.
    cycle(1, fe, 0, 0, '0, 0);
    cycle(1, ff, 0, 1, 8'd0, 0);
    chk("coll_rd_ready", last_rd_ready, 0);
    cycle(0, '0, 0, 1, 8'd0, 0);
    chk("coll_retry_ready", last_rd_ready, 1);
    idle();
    #2;
    chk("coll_rd_data", rd_data, fa);
    idle();

    // Saturation at RAM_DEPTH rows, then clear.
    cycle(0, '0, 0, 0, '0, 1);
    #2 chk("clr_count", count, 0);
    for (int unsigned i = 0; i < 255; i++) cycle(1, rnd(), 0, 0, '0, 0);
    cycle(0, '0, 1, 0, '0, 0);
    cycle(1, rnd(), 0, 0, '0, 0);
    cycle(1, rnd(), 0, 0, '0, 0);
    chk("full_wr_ready", last_wr_ready, 0);
    cycle(0, '0, 1, 0, '0, 0);
    #2 chk("full_count", count, 256);
    cycle(1, rnd(), 0, 0, '0, 0);
    chk("full_wr_ready2", last_wr_ready, 0);
    cycle(0, '0, 0, 0, '0, 1);
    #2 chk("clr2_count", count, 0);
    idle();
    chk("clr2_wr_ready", last_wr_ready, 1);

    // Randomized traffic.
    for (int unsigned i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 9) < 6, rnd(), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 3, AW'($urandom_range(0, 255)), $urandom_range(0, 99) == 0);
    end

    // Reset while holding a feature with a read in flight.
    cycle(0, '0, 0, 0, '0, 1);
    cycle(1, fa, 0, 0, '0, 0);
    cycle(1, fb, 0, 0, '0, 0);
    cycle(1, fc, 0, 0, '0, 0);
    cycle(0, '0, 0, 1, 8'd1, 0);
    #2 reset = 1'b1;
    wr_valid = 1'b1;
    rd_req = 1'b1;
    #1;
    reset_vals("arst");
    wr_valid = 1'b0;
    rd_req = 1'b0;
    model_reset();
    @(posedge clk);
    #1 reset_vals("arst_hold");
    #1 reset = 1'b0;
    for (int unsigned i = 0; i < 6; i++) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
